// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART Tx core among NUM_REQ
// byte sources, with per-source lock, tx_done watchdog and inter-frame gap.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req/req_lock        per-source request and hold-ownership lock
//   req_data            packed bytes, source i at [i*DATA_W +: DATA_W]
//   gnt                 one-cycle accept pulse, one-hot
//   tx_data/tx_start    byte and start pulse to the Tx core
//   tx_busy/tx_done     Tx core status
//   owner/active        current owner index, frame-in-progress flag
//   tmo_err             one-cycle pulse on watchdog abort
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 16,
  parameter int TMO_CYC = 20000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  input  logic                        tx_done,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        active,
  output logic                        tmo_err
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [OW-1:0]       r_ptr;
  logic [OW-1:0]       r_owner;
  logic                r_lock;
  logic [TW-1:0]       r_wdog;
  logic [GW-1:0]       r_gcnt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [DATA_W-1:0]   r_data;
  logic                r_start;
  logic                r_active;
  logic                r_tmo;

  logic [OW-1:0]       w_cand;
  logic [OW-1:0]       w_rr_win;
  logic [OW-1:0]       w_win;
  logic                w_lock_hit;
  logic [DATA_W-1:0]   w_data;
  logic                w_expire;

  // Scan downward so the candidate nearest ptr+1 is written last and wins.
  always_comb begin
    w_cand   = '0;
    w_rr_win = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = OW'((int'(r_ptr) + i) % NUM_REQ);
      if (req[w_cand]) begin
        w_rr_win = w_cand;
      end
    end
  end

  assign w_lock_hit = r_lock && req[r_owner];
  assign w_win      = w_lock_hit ? r_owner : w_rr_win;
  assign w_expire   = (r_wdog == TW'(TMO_CYC - 1));

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == OW'(i)) begin
        w_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= OW'(NUM_REQ - 1);
      r_owner  <= '0;
      r_lock   <= 1'b0;
      r_wdog   <= '0;
      r_gcnt   <= '0;
      r_gnt    <= '0;
      r_data   <= '0;
      r_start  <= 1'b0;
      r_active <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_gnt   <= '0;
      r_tmo   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (r_lock && !req[r_owner]) begin
            r_lock <= 1'b0;
          end
          if (|req && !tx_busy) begin
            r_owner  <= w_win;
            r_data   <= w_data;
            if (!w_lock_hit) begin
              r_ptr <= w_win;
            end
            r_start  <= 1'b1;
            r_gnt    <= NUM_REQ'(1) << w_win;
            r_active <= 1'b1;
            r_state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_lock  <= req_lock[r_owner];
          // Counts cycles since tx_start; the start cycle has elapsed.
          r_wdog  <= TW'(1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done || w_expire) begin
            // A done landing on the expiry cycle still counts as success.
            if (!tx_done) begin
              r_tmo  <= 1'b1;
              r_lock <= 1'b0;
            end
            if (GAP_CYC == 0) begin
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_gcnt  <= '0;
              r_state <= S_GAP;
            end
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gcnt == GW'(GAP_CYC - 1)) begin
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign tx_data  = r_data;
  assign tx_start = r_start;
  assign owner    = r_owner;
  assign active   = r_active;
  assign tmo_err  = r_tmo;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed bench for uart_tx_sched with a Tx core model,
// plus a GAP_CYC=0 instance for back-to-back launches.
module tb_uart_tx_sched;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int GAP = 4;
  localparam int TMO = 40;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_lock;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     gnt;
  logic [DW-1:0]     tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              tx_done;
  logic [1:0]        owner;
  logic              active;
  logic              tmo_err;

  logic [NR-1:0]     req0;
  logic [NR-1:0]     gnt0;
  logic [DW-1:0]     tx_data0;
  logic              tx_start0;
  logic              tx_done0;
  logic [1:0]        owner0;
  logic              active0;
  logic              tmo_err0;

  int n_run  = 0;
  int n_fail = 0;
  int done_dly;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .NUM_REQ(NR), .DATA_W(DW), .GAP_CYC(GAP), .TMO_CYC(TMO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_lock(req_lock), .req_data(req_data),
    .gnt(gnt), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .owner(owner), .active(active), .tmo_err(tmo_err)
  );

  uart_tx_sched #(
    .NUM_REQ(NR), .DATA_W(DW), .GAP_CYC(0), .TMO_CYC(TMO)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req(req0), .req_lock(4'b0000), .req_data(req_data),
    .gnt(gnt0), .tx_data(tx_data0), .tx_start(tx_start0),
    .tx_busy(1'b0), .tx_done(tx_done0),
    .owner(owner0), .active(active0), .tmo_err(tmo_err0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    req      = '0;
    req_lock = '0;
    tx_busy  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns -1 if no grant shows up inside the budget.
  task automatic wait_gnt(output int idx);
    idx = -1;
    for (int c = 0; c < 200 && idx < 0; c++) begin
      @(negedge clk);
      if (|gnt) begin
        for (int b = 0; b < NR; b++) begin
          if (gnt[b]) idx = b;
        end
        chk("gnt_onehot", $countones(gnt), 1);
        chk("start_with_gnt", tx_start, 1);
      end
    end
  endtask

  // Tx core model: tx_done pulses done_dly cycles after tx_start,
  // never when done_dly is 0.
  initial begin
    int cnt;
    cnt     = 0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else if (tx_start) begin
        cnt = done_dly;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_done = 1'b1;
      end
    end
  end

  initial begin
    int   w;
    logic seen;
    rst_n    = 1'b0;
    req      = '0;
    req_lock = '0;
    req_data = 32'h4433_2257;
    tx_busy  = 1'b0;
    req0     = '0;
    tx_done0 = 1'b0;
    done_dly = 10;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_start", tx_start, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_active", active, 0);
    chk("rst_owner", owner, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_tmo", tmo_err, 0);

    // 1: single request, timing of start/data/active
    do_reset();
    done_dly = 10;
    req = 4'b0001;
    @(negedge clk);
    chk("t1_start", tx_start, 1);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_owner", owner, 0);
    chk("t1_data", tx_data, 8'h57);
    chk("t1_active", active, 1);
    req  = '0;
    seen = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i <= 10 && tx_data !== 8'h57) seen = 1'b1;
      if (i == 1) begin
        chk("t1_start_pulse", tx_start, 0);
        chk("t1_gnt_pulse", gnt, 0);
      end
    end
    chk("t1_data_stable", seen, 0);
    chk("t1_active_gap", active, 1);
    @(negedge clk);
    chk("t1_active_end", active, 0);

    // 2: round robin
    do_reset();
    done_dly = 3;
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(w);
      chk("t2_rr2", w, i % 2);
    end
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(w);
      chk("t2_rr4", w, i % 4);
    end

    // 3: lock keeps source 1 for three bytes
    do_reset();
    req      = 4'b0110;
    req_lock = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(w);
      chk("t3_lock", w, 1);
      if (i == 2) req_lock = '0;
    end
    wait_gnt(w);
    chk("t3_after_lock", w, 2);

    // 4: watchdog abort clears lock
    do_reset();
    done_dly = 0;
    req      = 4'b0011;
    req_lock = 4'b0001;
    wait_gnt(w);
    chk("t4_first", w, 0);
    for (int i = 1; i <= TMO + 1; i++) begin
      @(negedge clk);
      if (i == 1) done_dly = 3;
      if (i == TMO - 1) chk("t4_tmo_early", tmo_err, 0);
      if (i == TMO) chk("t4_tmo", tmo_err, 1);
      if (i == TMO + 1) chk("t4_tmo_pulse", tmo_err, 0);
    end
    wait_gnt(w);
    chk("t4_next_rr", w, 1);

    // 4b: done on the expiry cycle wins
    do_reset();
    done_dly = TMO - 1;
    req = 4'b0001;
    wait_gnt(w);
    chk("t4b_gnt", w, 0);
    req  = '0;
    seen = 1'b0;
    for (int i = 1; i <= TMO + 6; i++) begin
      @(negedge clk);
      if (tmo_err) seen = 1'b1;
    end
    chk("t4b_no_tmo", seen, 0);
    chk("t4b_idle", active, 0);

    // 5: busy core blocks launch
    do_reset();
    done_dly = 3;
    tx_busy  = 1'b1;
    req      = 4'b0001;
    seen     = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (|gnt) seen = 1'b1;
    end
    chk("t5_no_gnt", seen, 0);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("t5_gnt", gnt, 4'b0001);
    chk("t5_start", tx_start, 1);

    // 6: async reset mid-frame, then source 3 first
    do_reset();
    done_dly = 0;
    req = 4'b0100;
    wait_gnt(w);
    chk("t6_gnt", w, 2);
    req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_active", active, 0);
    chk("t6_rst_owner", owner, 0);
    chk("t6_rst_data", tx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1000;
    @(negedge clk);
    chk("t6_gnt3", gnt, 4'b1000);
    chk("t6_owner3", owner, 3);
    req = '0;

    // 6b: GAP_CYC=0 gives back-to-back launches
    req0 = 4'b0001;
    @(negedge clk);
    chk("t6b_start", tx_start0, 1);
    chk("t6b_gnt", gnt0, 4'b0001);
    chk("t6b_data", tx_data0, 8'h57);
    @(negedge clk);
    tx_done0 = 1'b1;
    @(negedge clk);
    tx_done0 = 1'b0;
    chk("t6b_idle", active0, 0);
    chk("t6b_nostart", tx_start0, 0);
    @(negedge clk);
    chk("t6b_restart", tx_start0, 1);
    chk("t6b_owner", owner0, 0);
    chk("t6b_tmo", tmo_err0, 0);
    req0 = '0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
